// File: rtl/xadc_pkg.sv
// -----------------------------------------------------------------------------
// xadc_pkg
// Shared definitions for the XADC DRP arbiter:
//   - DRP bus widths
//   - well-known XADC register addresses used by the requesters
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package xadc_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  // Status registers polled by the sample reader
  localparam logic [DRP_ADDR_W-1:0] ADDR_TEMP     = 7'h00;
  localparam logic [DRP_ADDR_W-1:0] ADDR_AUX0     = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] ADDR_AUX1     = 7'h11;
  localparam logic [DRP_ADDR_W-1:0] ADDR_AUX2     = 7'h12;
  localparam logic [DRP_ADDR_W-1:0] ADDR_AUX3     = 7'h13;

  // Configuration registers updated by the configuration writer
  localparam logic [DRP_ADDR_W-1:0] ADDR_CFG0     = 7'h40;
  localparam logic [DRP_ADDR_W-1:0] ADDR_CFG1     = 7'h41;
  localparam logic [DRP_ADDR_W-1:0] ADDR_CFG2     = 7'h42;
  localparam logic [DRP_ADDR_W-1:0] ADDR_SEQ_BASE = 7'h48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for any request
    ST_ISSUE = 2'd1,  // DEN pulse and REQ_READY to the winner
    ST_WAIT  = 2'd2,  // waiting for DRDY or timeout
    ST_RESP  = 2'd3   // RSP_VALID pulse to the owner
  } arb_state_e;

endpackage : xadc_pkg

// File: rtl/xadc_rr_pick.sv
// -----------------------------------------------------------------------------
// xadc_rr_pick
// Combinational round-robin selector. The search begins at the requester after
// i_last (wrapping at NUM_REQ-1) and returns the first requester whose bit is
// set in i_req.
//   i_req   : request vector, one bit per requester
//   i_last  : index of the most recently served requester
//   o_grant : one-hot grant (all zero when nothing is requested)
//   o_idx   : index of the granted requester (0 when nothing is requested)
// -----------------------------------------------------------------------------
module xadc_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  always_comb begin
    logic [IDX_W-1:0] probe;
    logic             found;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    probe   = i_last;
    // Walk once around the ring starting just after the last winner; the
    // explicit wrap keeps this correct when NUM_REQ is not a power of two.
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = (probe == LAST_IDX) ? '0 : probe + 1'b1;
      if (!found && i_req[probe]) begin
        found          = 1'b1;
        o_idx          = probe;
        o_grant[probe] = 1'b1;
      end
    end
  end

endmodule : xadc_rr_pick

// File: rtl/xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// xadc_drp_arbiter
// Shares one XADC DRP port between NUM_REQ requesters. One DRP transaction is
// in flight at a time; requesters are served round-robin. A saturating 8-bit
// counter aborts a transaction whose DRDY never arrives (RSP_ERR=1, data FFFF).
// All outputs are registered.
//   i_dclk, i_reset_n          : DRP clock, asynchronous active-low reset
//   i_req_valid/we/addr/wdata  : per-requester request (addr/wdata packed)
//   o_req_ready                : one-cycle accept pulse to the winner
//   o_rsp_valid/rdata/err      : one-cycle completion to the owner
//   o_drp_* / i_drp_*          : XADC DRP primitive connection
//   o_arb_busy                 : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int NUM_REQ = 4,   // 2..8
  parameter int TIMEOUT = 63   // 1..255
) (
  input  logic                          i_dclk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [DRP_ADDR_W*NUM_REQ-1:0] i_req_addr,
  input  logic [DRP_DATA_W*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DRP_DATA_W-1:0]         o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [DRP_ADDR_W-1:0]         o_drp_daddr,
  output logic                          o_drp_den,
  output logic                          o_drp_dwe,
  output logic [DRP_DATA_W-1:0]         o_drp_di,
  input  logic [DRP_DATA_W-1:0]         i_drp_do,
  input  logic                          i_drp_drdy,
  output logic                          o_arb_busy
);

  localparam int                 IDX_W       = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);

  // Registered state
  arb_state_e            r_state;
  logic [7:0]            r_cnt;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_last;
  logic                  r_we;
  logic [DRP_ADDR_W-1:0] r_addr;
  logic [DRP_DATA_W-1:0] r_wdata;
  logic [DRP_DATA_W-1:0] r_rdata;
  logic                  r_err;
  logic [NUM_REQ-1:0]    r_ready;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_den;
  logic                  r_dwe;
  logic                  r_busy;

  // Next-state values
  arb_state_e            w_state_d;
  logic [7:0]            w_cnt_d;
  logic [IDX_W-1:0]      w_owner_d;
  logic [IDX_W-1:0]      w_last_d;
  logic                  w_we_d;
  logic [DRP_ADDR_W-1:0] w_addr_d;
  logic [DRP_DATA_W-1:0] w_wdata_d;
  logic [DRP_DATA_W-1:0] w_rdata_d;
  logic                  w_err_d;
  logic [NUM_REQ-1:0]    w_ready_d;
  logic [NUM_REQ-1:0]    w_rsp_valid_d;
  logic                  w_den_d;
  logic                  w_dwe_d;

  // Arbitration
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_sel_we;
  logic [DRP_ADDR_W-1:0] w_sel_addr;
  logic [DRP_DATA_W-1:0] w_sel_wdata;

  xadc_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  // One-hot mux of the winner's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_we    = i_req_we[j];
        w_sel_addr  = i_req_addr[j*DRP_ADDR_W +: DRP_ADDR_W];
        w_sel_wdata = i_req_wdata[j*DRP_DATA_W +: DRP_DATA_W];
      end
    end
  end

  // Next-state and next-output logic. Pulse outputs default low; latched
  // transaction fields default to holding.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_owner_d     = r_owner;
    w_last_d      = r_last;
    w_we_d        = r_we;
    w_addr_d      = r_addr;
    w_wdata_d     = r_wdata;
    w_rdata_d     = r_rdata;
    w_err_d       = 1'b0;
    w_ready_d     = '0;
    w_rsp_valid_d = '0;
    w_den_d       = 1'b0;
    w_dwe_d       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (|i_req_valid) begin
          w_state_d = ST_ISSUE;
          w_owner_d = w_grant_idx;
          w_we_d    = w_sel_we;
          w_addr_d  = w_sel_addr;
          w_wdata_d = w_sel_wdata;
          // Outputs are registered, so the ISSUE-cycle pulses are loaded here.
          w_ready_d = w_grant;
          w_den_d   = 1'b1;
          w_dwe_d   = w_sel_we;
          w_cnt_d   = '0;
        end
      end

      ST_ISSUE: begin
        w_state_d = ST_WAIT;
        w_cnt_d   = '0;
      end

      ST_WAIT: begin
        // DRDY is checked first so a DRDY on the timeout cycle still succeeds.
        if (i_drp_drdy) begin
          w_state_d     = ST_RESP;
          w_rdata_d     = r_we ? '0 : i_drp_do;
          w_err_d       = 1'b0;
          w_rsp_valid_d = ONE_HOT0 << r_owner;
          w_last_d      = r_owner;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_state_d     = ST_RESP;
          w_rdata_d     = '1;
          w_err_d       = 1'b1;
          w_rsp_valid_d = ONE_HOT0 << r_owner;
          w_last_d      = r_owner;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end

      ST_RESP: begin
        w_state_d = ST_IDLE;
        // DADDR/DI read zero while idle.
        w_addr_d  = '0;
        w_wdata_d = '0;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_dclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= '0;
      r_last      <= LAST_IDX;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_ready     <= '0;
      r_rsp_valid <= '0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_owner     <= w_owner_d;
      r_last      <= w_last_d;
      r_we        <= w_we_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_rdata     <= w_rdata_d;
      r_err       <= w_err_d;
      r_ready     <= w_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_den       <= w_den_d;
      r_dwe       <= w_dwe_d;
      r_busy      <= (w_state_d != ST_IDLE);
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_drp_daddr = r_addr;
  assign o_drp_den   = r_den;
  assign o_drp_dwe   = r_dwe;
  assign o_drp_di    = r_wdata;
  assign o_arb_busy  = r_busy;

endmodule : xadc_drp_arbiter

// File: tb/tb_xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_arbiter
// Cycle-stepped bench: requester agents and a DRP responder drive the DUT, and
// a transaction-level reference (round-robin choice, response time
// issue + min(delay, TIMEOUT+1) + 1, FFFF/err on timeout) predicts every
// output each cycle. A table of directed transactions, hand-written
// fairness/reset sequences and a randomized phase are run in turn.
// -----------------------------------------------------------------------------
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  localparam int N = 4;
  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [7*N-1:0]  req_addr;
  logic [16*N-1:0] req_wdata;
  logic [15:0]     rsp_rdata, drp_di, drp_do;
  logic [6:0]      drp_daddr;
  logic            rsp_err, drp_den, drp_dwe, drp_drdy, arb_busy;

  xadc_drp_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (T)
  ) dut (
    .i_dclk      (clk),
    .i_reset_n   (rst_n),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_drp_daddr (drp_daddr),
    .o_drp_den   (drp_den),
    .o_drp_dwe   (drp_dwe),
    .o_drp_di    (drp_di),
    .i_drp_do    (drp_do),
    .i_drp_drdy  (drp_drdy),
    .o_arb_busy  (arb_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester agents
  logic [N-1:0] a_pend, a_we;
  logic [6:0]   a_addr  [N];
  logic [15:0]  a_wdata [N];
  int           mode;  // 0 directed, 1 all hold, 2 random

  // DRP responder parameters for the next accepted transaction
  int          nx_delay;
  logic [15:0] nx_val;
  int          drdy_at = -1000;

  // Reference model state
  bit          m_act;
  int          m_owner, m_last, m_issue, m_rsp_at, m_delay;
  bit          m_we;
  logic [6:0]  m_addr;
  logic [15:0] m_wdata, m_val;
  bit          p_win;
  logic [N-1:0] p_vec, p_we;
  logic [6:0]  p_addr  [N];
  logic [15:0] p_wdata [N];

  // Observations of the DUT
  int          t_den, t_rsp, den_cnt, seen_idx;
  logic [15:0] seen_rdata;
  logic        seen_err;
  int          grant_log[$];
  int          issue_log[$];

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*7 +: 7]    = a_addr[i];
      req_wdata[i*16 +: 16] = a_wdata[i];
      p_addr[i]             = a_addr[i];
      p_wdata[i]            = a_wdata[i];
    end
    req_valid = a_pend;
    req_we    = a_we;
    p_vec     = a_pend;
    p_we      = a_we;
  endtask

  task automatic model_reset();
    m_act   = 1'b0;
    m_last  = N - 1;
    p_win   = 1'b1;
    drdy_at = -1000;
    a_pend  = '0;
    apply_inputs();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"},  {req_ready, rsp_valid, rsp_err, drp_den, drp_dwe, arb_busy}, 0);
    check({tag, "_daddr"}, drp_daddr, 0);
    check({tag, "_di"},    drp_di, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
  endtask

  // One clock: observe and check at the falling edge, then drive new inputs.
  task automatic step();
    bit           issue_now, rsp_now, timed_out, win;
    int           w;
    logic [N-1:0] e_ready, e_rsp;
    @(negedge clk);
    cyc++;
    issue_now = 1'b0;
    w = 0;
    if (p_win && (p_vec != '0)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!issue_now && p_vec[c]) begin
          issue_now = 1'b1;
          w = c;
        end
      end
      if (mode == 2) begin
        case ($urandom_range(0, 9))
          0:       nx_delay = T + 2;
          1:       nx_delay = T + 3;
          2:       nx_delay = 255;
          3:       nx_delay = T + 1;
          default: nx_delay = int'($urandom_range(1, T));
        endcase
        nx_val = 16'($urandom);
      end
      m_act    = 1'b1;
      m_owner  = w;
      m_we     = p_we[w];
      m_addr   = p_addr[w];
      m_wdata  = p_wdata[w];
      m_issue  = cyc;
      m_delay  = nx_delay;
      m_val    = nx_val;
      m_rsp_at = cyc + ((m_delay < T + 1) ? m_delay : T + 1) + 1;
      drdy_at  = cyc + m_delay;
      grant_log.push_back(w);
      issue_log.push_back(cyc);
    end
    rsp_now   = m_act && (cyc == m_rsp_at);
    timed_out = (m_delay > T + 1);
    e_ready   = issue_now ? (N'(1) << w) : '0;
    e_rsp     = rsp_now ? (N'(1) << m_owner) : '0;

    check("req_ready", req_ready, e_ready);
    check("drp_den",   drp_den, issue_now);
    check("drp_dwe",   drp_dwe, issue_now && m_we);
    check("drp_daddr", drp_daddr, m_act ? m_addr : 7'h00);
    check("drp_di",    drp_di, m_act ? m_wdata : 16'h0000);
    check("arb_busy",  arb_busy, m_act);
    check("rsp_valid", rsp_valid, e_rsp);
    if (rsp_now) begin
      check("rsp_rdata", rsp_rdata, timed_out ? 16'hFFFF : (m_we ? 16'h0000 : m_val));
      check("rsp_err",   rsp_err, timed_out);
    end

    if (drp_den) den_cnt++;
    if (drp_den && t_den < 0) t_den = cyc;
    if ((|rsp_valid) && t_rsp < 0) begin
      t_rsp      = cyc;
      seen_rdata = rsp_rdata;
      seen_err   = rsp_err;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) seen_idx = i;
    end

    win = !m_act;
    if (rsp_now) begin
      m_act  = 1'b0;
      m_last = m_owner;
    end

    for (int i = 0; i < N; i++) if (req_ready[i]) a_pend[i] = 1'b0;
    if (mode == 1) begin
      a_pend = '1;
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (!a_pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            a_pend[i]  = 1'b1;
            a_we[i]    = 1'($urandom);
            a_addr[i]  = 7'($urandom);
            a_wdata[i] = 16'($urandom);
          end
        end else if ($urandom_range(0, 31) == 0) begin
          a_pend[i] = 1'b0;
        end
      end
    end

    drp_drdy = (cyc == drdy_at);
    drp_do   = drp_drdy ? m_val : 16'($urandom);
    apply_inputs();
    p_win = win;
  endtask

  task automatic drain();
    mode   = 0;
    a_pend = '0;
    apply_inputs();
    for (int s = 0; s < 300 && m_act; s++) step();
    repeat (2) step();
  endtask

  typedef struct {
    int          req;
    bit          we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          delay;      // DRDY arrives this many cycles after DEN
    logic [15:0] drp_val;    // DO driven with DRDY
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;    // cycles from DEN to RSP_VALID
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  initial begin
    vec_t cv;
    mode     = 0;
    a_we     = '0;
    drp_drdy = 1'b0;
    drp_do   = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = '0;
      a_wdata[i] = '0;
    end
    model_reset();

    vecs[0] = '{0, 1'b0, ADDR_AUX0,     16'h0000, 2,     16'h5A5A, 16'h5A5A, 1'b0, 3};
    vecs[1] = '{2, 1'b1, ADDR_CFG0,     16'h03FF, 1,     16'h1111, 16'h0000, 1'b0, 2};
    vecs[2] = '{1, 1'b0, ADDR_TEMP,     16'h0000, T + 1, 16'h1234, 16'h1234, 1'b0, 12};
    vecs[3] = '{3, 1'b0, ADDR_AUX3,     16'h0000, 255,   16'h7777, 16'hFFFF, 1'b1, 12};
    vecs[4] = '{1, 1'b1, ADDR_SEQ_BASE, 16'h00AA, T + 2, 16'h2222, 16'hFFFF, 1'b1, 12};
    vecs[5] = '{0, 1'b0, ADDR_AUX2,     16'h0000, T + 3, 16'h3333, 16'hFFFF, 1'b1, 12};
    vecs[6] = '{3, 1'b0, ADDR_CFG1,     16'h0000, 1,     16'hBEEF, 16'hBEEF, 1'b0, 2};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Directed table
    for (int v = 0; v < NVEC; v++) begin
      int t_start;
      cv = vecs[v];
      a_pend[cv.req]  = 1'b1;
      a_we[cv.req]    = cv.we;
      a_addr[cv.req]  = cv.addr;
      a_wdata[cv.req] = cv.wdata;
      nx_delay = cv.delay;
      nx_val   = cv.drp_val;
      apply_inputs();
      t_start = cyc;
      t_den   = -1;
      t_rsp   = -1;
      den_cnt = 0;
      for (int s = 0; s < 60 && t_rsp < 0; s++) step();
      repeat (4) step();
      check("vec_rsp_seen",  (t_rsp >= 0), 1);
      check("vec_issue_lat", t_den - t_start, 1);
      check("vec_rsp_lat",   t_rsp - t_den, cv.exp_lat);
      check("vec_rdata",     seen_rdata, cv.exp_rdata);
      check("vec_err",       seen_err, cv.exp_err);
      check("vec_owner",     seen_idx, cv.req);
      check("vec_den_count", den_cnt, 1);
    end

    // Fairness: everyone requests continuously
    mode = 1;
    for (int i = 0; i < N; i++) begin
      a_we[i]   = 1'b0;
      a_addr[i] = 7'(ADDR_AUX0 + i);
    end
    nx_delay = 1;
    nx_val   = 16'hC0DE;
    grant_log.delete();
    issue_log.delete();
    a_pend = '1;
    apply_inputs();
    repeat (40) step();
    drain();
    check("rr_count", (grant_log.size() >= 8), 1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("rr_order", grant_log[k], k % N);
    for (int k = 0; k < 7 && k + 1 < issue_log.size(); k++)
      check("rr_spacing", issue_log[k+1] - issue_log[k], 4);

    // Reset while waiting for DRDY
    a_pend[2] = 1'b1;
    a_we[2]   = 1'b0;
    a_addr[2] = ADDR_AUX2;
    nx_delay  = 255;
    nx_val    = 16'h4444;
    apply_inputs();
    for (int s = 0; s < 20 && !(m_act && cyc >= m_issue + 2); s++) step();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_wait");
    drp_drdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("rst_hold");
    rst_n = 1'b1;
    repeat (3) step();
    grant_log.delete();
    a_pend[0] = 1'b1;
    a_pend[3] = 1'b1;
    a_we[0]   = 1'b0;
    a_we[3]   = 1'b0;
    nx_delay  = 1;
    apply_inputs();
    for (int s = 0; s < 10 && grant_log.size() == 0; s++) step();
    check("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    for (int s = 0; s < 40 && (m_act || a_pend != '0); s++) step();
    drain();

    // Randomized traffic
    mode = 2;
    repeat (1500) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_xadc_drp_arbiter
